decode_stage: RTL
=================

Name: decode_stage

Overview:
Parametrised RV32I/RV32M decode stage sitting between fetch and execute. It replaces the stall-based control register with a valid/ready handshake, an optional skid buffer and a synchronous flush. It also adds rs1/rs2 extraction, immediate generation and illegal-instruction detection. One registered pipeline stage; all outputs come from flops.

Parameters:
XLEN, 32, width of pc and immediate paths (sign-extend to XLEN).
HAS_M, 0, 1 = decode funct7=0x01 RegReg ops as M-extension; 0 = those encodings are illegal.
SKID, 1, 1 = two-entry skid buffer (in_ready independent of out_ready); 0 = single register, in_ready = !out_valid || out_ready.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
flush  in  1  discard all held and incoming instructions
in_valid  in  1  fetch has an instruction
in_ready  out  1  stage can accept
in_insn  in  32  raw instruction
in_pc  in  XLEN  instruction address
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute accepts bundle
out_pc  out  XLEN  pc of bundle
out_op  out  5  shared Op enum (Add=0 … USub), extended with Mul, Mulh, Mulhsu, Mulhu, Div, Divu, Rem, Remu
out_rd, out_rs1, out_rs2  out  5 each  register indices
out_imm  out  XLEN  sign-extended immediate
out_asel  out  1  0 = Register, 1 = ProgramCounter
out_bsel  out  1  0 = Register, 1 = Immediate
out_pcsel  out  1  1 for Jalr
out_cond  out  3  Never=0, Always, Zero, NotZero, Carry, NotCarry
out_memr, out_memw  out  1 each  load / store
out_memt  out  3  LoadByte=0, LoadHalf, LoadWord, ULoadByte, ULoadHalf, StoreByte, StoreHalf, StoreWord
out_illegal  out  1  bundle is an illegal instruction

Behaviour:
- Reset (async): out_valid=0; every out_* field = 0 (op=Add, cond=Never, memt=LoadByte). Skid empty. in_ready=1.
- Transfers: a transfer occurs when valid && ready on a port. Latency is 1 cycle: an accepted instruction appears on out_* the next cycle.
- SKID=1 states:
  - EMPTY: in_ready=1.
    - Input transfer → ONE.
  - ONE: output register full, in_ready=1.
    - Output transfer without input transfer → EMPTY.
    - Input transfer while out_ready=0 → decoded insn goes into the skid → FULL.
    - Input and output transfer together → stay ONE with the new bundle.
  - FULL: in_ready=0.
    - Output transfer → skid moves to output → ONE.
- Order is always preserved. The output register never changes while out_valid && !out_ready.
- flush: highest priority after rst. Next cycle the state is EMPTY and out_valid=0. An input presented in the flush cycle is dropped. Field values are don't-care once invalid.
- Decode (same rules for both registers):
  - RegReg: op from funct3/funct7 (Add/Sub, Xor, Shl, Shr/Asr, Or, And, Slt, USlt); funct7=0x01 gives M ops when HAS_M; asel=0, bsel=0.
  - RegImm: as RegReg using imm[11:5] for shifts; bsel=1.
  - Branch: op=Sub for funct3 0/1/4/5, USub for 6/7; cond Zero/NotZero/Carry/NotCarry/Carry/NotCarry; rd=0.
  - Jal: asel=1, bsel=1, cond=Always.
  - Jalr: asel=1, bsel=1, cond=Always, pcsel=1.
  - Load: memr=1, memt from funct3 0/1/2/4/5; bsel=1.
  - Store: memw=1, memt from funct3 0/1/2; rd=0; bsel=1.
  - Lui: rs1 forced 0, bsel=1.
  - Auipc: asel=1, bsel=1.
- Immediate by format, sign-extended from insn[31]:
  - I: insn[31:20].
  - S: {insn[31:25], insn[11:7]}.
  - B: {insn[31], insn[7], insn[30:25], insn[11:8], 0}.
  - U: {insn[31:12], 12'b0}.
  - J: {insn[31], insn[19:12], insn[20], insn[30:21], 0}.
  - R-type: 0.
- rs2 = 0 for formats without rs2.
- Illegal: any of the following.
  - insn[1:0] != 2'b11.
  - Unknown opcode.
  - Undefined funct3/funct7 combination.
  - Load funct3 3/6/7.
  - Store funct3 > 2.
  - M op with HAS_M=0.
- An illegal bundle is a NOP: op=Add, rd=0, memr=memw=0, cond=Never, pcsel=0, out_illegal=1. out_pc is kept so the trap handler can use it.

Test Plan:
- Reset mid-stream with out_valid=1 and skid full → out_valid=0 and in_ready=1 immediately; all fields zero.
- 0x00500093 (addi x1,x0,5) with out_ready=1 → next cycle: op=Add, rd=1, rs1=0, imm=5, bsel=1, cond=Never, illegal=0.
- 0xFE208EE3 (beq x1,x2,-4) → op=Sub, rs1=1, rs2=2, rd=0, imm=0xFFFFFFFC, cond=Zero. 0x123452B7 (lui x5) → imm=0x12345000, rs1=0, rd=5.
- 0x022081B3 (mul x3,x1,x2): HAS_M=1 → op=Mul, rd=3; HAS_M=0 → illegal=1, rd=0, op=Add.
- SKID=1: out_ready=0 while sending pc 0x0, 0x4, 0x8 → in_ready falls after the second accept; 0x8 is held at input. Raise out_ready → outputs 0x0, 0x4, 0x8 on consecutive cycles, none lost or duplicated.
- State FULL, flush=1 with in_valid=1 → next cycle out_valid=0, EMPTY; the flushed-cycle input is never output.

Source files
------------

// File: rtl/decode_stage_if.sv
// Handshake bundle between fetch, the decode stage and execute.
// The slave modport is the decode stage; the master modport is its environment.
interface decode_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_insn;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      out_op;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [XLEN-1:0] out_imm;
    logic            out_asel;
    logic            out_bsel;
    logic            out_pcsel;
    logic [2:0]      out_cond;
    logic            out_memr;
    logic            out_memw;
    logic [2:0]      out_memt;
    logic            out_illegal;

    modport master (
        output in_valid, in_insn, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_op, out_rd, out_rs1, out_rs2,
               out_imm, out_asel, out_bsel, out_pcsel, out_cond, out_memr,
               out_memw, out_memt, out_illegal
    );

    modport slave (
        input  in_valid, in_insn, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_op, out_rd, out_rs1, out_rs2,
               out_imm, out_asel, out_bsel, out_pcsel, out_cond, out_memr,
               out_memw, out_memt, out_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I/RV32M decode stage: valid/ready handshake, optional two-entry skid buffer,
// synchronous flush, register/immediate extraction and illegal-instruction detection.
module decode_stage #(
    parameter int XLEN  = 32,
    parameter bit HAS_M = 1'b0,
    parameter bit SKID  = 1'b1
) (
    input logic           clk,
    input logic           rst,
    input logic           flush,
    decode_stage_if.slave bus
);

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;

    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_XOR, OP_SHL, OP_SHR, OP_ASR, OP_OR, OP_AND,
        OP_SLT, OP_USLT, OP_USUB,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } op_e;

    typedef enum logic [2:0] {
        COND_NEVER, COND_ALWAYS, COND_ZERO, COND_NOTZERO, COND_CARRY, COND_NOTCARRY
    } cond_e;

    typedef enum logic [2:0] {
        MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
    } memt_e;

    typedef enum logic [1:0] {
        S_EMPTY, S_ONE, S_FULL
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        op_e             op;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic            asel;
        logic            bsel;
        logic            pcsel;
        cond_e           cond;
        logic            memr;
        logic            memw;
        memt_e           memt;
        logic            illegal;
    } bundle_t;

    function automatic logic [XLEN-1:0] imm_i(input logic [31:0] insn);
        return {{(XLEN-12){insn[31]}}, insn[31:20]};
    endfunction

    function automatic logic [XLEN-1:0] imm_s(input logic [31:0] insn);
        return {{(XLEN-12){insn[31]}}, insn[31:25], insn[11:7]};
    endfunction

    function automatic logic [XLEN-1:0] imm_b(input logic [31:0] insn);
        return {{(XLEN-13){insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
    endfunction

    function automatic logic [XLEN-1:0] imm_u(input logic [31:0] insn);
        return {{(XLEN-32){insn[31]}}, insn[31:12], 12'b0};
    endfunction

    function automatic logic [XLEN-1:0] imm_j(input logic [31:0] insn);
        return {{(XLEN-21){insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
    endfunction

    // funct7=0x00 ALU mapping shared by register and immediate forms.
    function automatic op_e alu_op(input logic [2:0] f3);
        op_e op;
        case (f3)
            3'd0:    op = OP_ADD;
            3'd1:    op = OP_SHL;
            3'd2:    op = OP_SLT;
            3'd3:    op = OP_USLT;
            3'd4:    op = OP_XOR;
            3'd5:    op = OP_SHR;
            3'd6:    op = OP_OR;
            default: op = OP_AND;
        endcase
        return op;
    endfunction

    function automatic op_e mul_op(input logic [2:0] f3);
        op_e op;
        case (f3)
            3'd0:    op = OP_MUL;
            3'd1:    op = OP_MULH;
            3'd2:    op = OP_MULHSU;
            3'd3:    op = OP_MULHU;
            3'd4:    op = OP_DIV;
            3'd5:    op = OP_DIVU;
            3'd6:    op = OP_REM;
            default: op = OP_REMU;
        endcase
        return op;
    endfunction

    // Formats without an rs1/rs2 field report register 0 so hazard logic sees no dependency.
    function automatic bundle_t decode(input logic [31:0] insn, input logic [XLEN-1:0] pc);
        bundle_t    b;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       bad;
        b     = '0;
        f3    = insn[14:12];
        f7    = insn[31:25];
        bad   = (insn[1:0] != 2'b11);
        b.pc  = pc;
        b.rd  = insn[11:7];
        b.rs1 = insn[19:15];
        b.rs2 = insn[24:20];
        case (insn[6:0])
            OPC_OP: begin
                if (f7 == 7'h00) begin
                    b.op = alu_op(f3);
                end else if (f7 == 7'h20 && f3 == 3'd0) begin
                    b.op = OP_SUB;
                end else if (f7 == 7'h20 && f3 == 3'd5) begin
                    b.op = OP_ASR;
                end else if (f7 == 7'h01 && HAS_M) begin
                    b.op = mul_op(f3);
                end else begin
                    bad = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                b.rs2  = '0;
                b.bsel = 1'b1;
                b.imm  = imm_i(insn);
                b.op   = alu_op(f3);
                if (f3 == 3'd1 && f7 != 7'h00) begin
                    bad = 1'b1;
                end else if (f3 == 3'd5) begin
                    if (f7 == 7'h20) begin
                        b.op = OP_ASR;
                    end else if (f7 != 7'h00) begin
                        bad = 1'b1;
                    end
                end
            end
            OPC_BRANCH: begin
                b.rd  = '0;
                b.imm = imm_b(insn);
                b.op  = (f3[2:1] == 2'b11) ? OP_USUB : OP_SUB;
                case (f3)
                    3'd0:       b.cond = COND_ZERO;
                    3'd1:       b.cond = COND_NOTZERO;
                    3'd4, 3'd6: b.cond = COND_CARRY;
                    3'd5, 3'd7: b.cond = COND_NOTCARRY;
                    default:    bad = 1'b1;
                endcase
            end
            OPC_JAL: begin
                b.rs1  = '0;
                b.rs2  = '0;
                b.imm  = imm_j(insn);
                b.asel = 1'b1;
                b.bsel = 1'b1;
                b.cond = COND_ALWAYS;
            end
            OPC_JALR: begin
                b.rs2   = '0;
                b.imm   = imm_i(insn);
                b.asel  = 1'b1;
                b.bsel  = 1'b1;
                b.cond  = COND_ALWAYS;
                b.pcsel = 1'b1;
                bad     = bad | (f3 != 3'd0);
            end
            OPC_LOAD: begin
                b.rs2  = '0;
                b.imm  = imm_i(insn);
                b.bsel = 1'b1;
                b.memr = 1'b1;
                case (f3)
                    3'd0:    b.memt = MEM_LB;
                    3'd1:    b.memt = MEM_LH;
                    3'd2:    b.memt = MEM_LW;
                    3'd4:    b.memt = MEM_LBU;
                    3'd5:    b.memt = MEM_LHU;
                    default: bad = 1'b1;
                endcase
            end
            OPC_STORE: begin
                b.rd   = '0;
                b.imm  = imm_s(insn);
                b.bsel = 1'b1;
                b.memw = 1'b1;
                case (f3)
                    3'd0:    b.memt = MEM_SB;
                    3'd1:    b.memt = MEM_SH;
                    3'd2:    b.memt = MEM_SW;
                    default: bad = 1'b1;
                endcase
            end
            OPC_LUI: begin
                b.rs1  = '0;
                b.rs2  = '0;
                b.imm  = imm_u(insn);
                b.bsel = 1'b1;
            end
            OPC_AUIPC: begin
                b.rs1  = '0;
                b.rs2  = '0;
                b.imm  = imm_u(insn);
                b.asel = 1'b1;
                b.bsel = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        // Illegal bundles become a NOP that still carries the faulting pc.
        if (bad) begin
            b         = '0;
            b.pc      = pc;
            b.illegal = 1'b1;
        end
        return b;
    endfunction

    state_e  state_q, state_d;
    bundle_t out_q, out_d;
    bundle_t skid_q, skid_d;
    bundle_t dec;
    logic    out_valid_q, out_valid_d;
    logic    in_ready_q, in_ready_d;
    logic    in_ready;
    logic    in_fire;
    logic    out_fire;

    assign in_ready = SKID ? in_ready_q : (!out_valid_q || bus.out_ready);
    assign in_fire  = bus.in_valid && in_ready;
    assign out_fire = out_valid_q && bus.out_ready;

    always_comb begin
        dec      = decode(bus.in_insn, bus.in_pc);
        state_d  = state_q;
        out_d    = out_q;
        skid_d   = skid_q;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (in_fire) begin
                        out_d   = dec;
                        state_d = S_ONE;
                    end
                end
                S_ONE: begin
                    if (in_fire && !out_fire && SKID) begin
                        skid_d  = dec;
                        state_d = S_FULL;
                    end else if (in_fire) begin
                        out_d   = dec;
                    end else if (out_fire) begin
                        state_d = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (out_fire) begin
                        out_d   = skid_q;
                        state_d = S_ONE;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
        out_valid_d = (state_d != S_EMPTY);
        in_ready_d  = (state_d != S_FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            out_q       <= out_d;
        end
    end

    // Skid contents are only meaningful in S_FULL, so they carry no reset.
    always_ff @(posedge clk) begin
        skid_q <= skid_d;
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_pc      = out_q.pc;
    assign bus.out_op      = out_q.op;
    assign bus.out_rd      = out_q.rd;
    assign bus.out_rs1     = out_q.rs1;
    assign bus.out_rs2     = out_q.rs2;
    assign bus.out_imm     = out_q.imm;
    assign bus.out_asel    = out_q.asel;
    assign bus.out_bsel    = out_q.bsel;
    assign bus.out_pcsel   = out_q.pcsel;
    assign bus.out_cond    = out_q.cond;
    assign bus.out_memr    = out_q.memr;
    assign bus.out_memw    = out_q.memw;
    assign bus.out_memt    = out_q.memt;
    assign bus.out_illegal = out_q.illegal;

endmodule
